// File: rtl/fusion_pkg.sv
// -----------------------------------------------------------------------------
// fusion_pkg
// Shared definitions for the sensor pairing front end of the fusion core:
// the default sample width, the output mask encoding, the paired-beat struct
// and the arbitration select used by sensor_pair_aligner.
// -----------------------------------------------------------------------------
package fusion_pkg;

  localparam int DATA_W = 16;

  // Output mask encoding: bit0 = IMU field valid, bit1 = LiDAR field valid.
  localparam logic [1:0] MASK_NONE  = 2'b00;
  localparam logic [1:0] MASK_IMU   = 2'b01;
  localparam logic [1:0] MASK_LIDAR = 2'b10;
  localparam logic [1:0] MASK_PAIR  = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] imu;
    logic [DATA_W-1:0] lidar;
    logic [1:0]        mask;
  } sensor_pair_t;

  // Which FIFO(s) the output stage takes its next beat from.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PAIR,
    SEL_IMU,
    SEL_LIDAR
  } sel_t;

endpackage

// File: rtl/sensor_pair_aligner_if.sv
// -----------------------------------------------------------------------------
// sensor_pair_aligner_if
// Valid/ready output beat between the aligner and the fusion core.
//   out_imu   : paired IMU field (0 when not in mask)
//   out_lidar : paired LiDAR field (0 when not in mask)
//   out_mask  : bit0 = IMU field valid, bit1 = LiDAR field valid
//   out_valid : beat valid, held until accepted
//   out_ready : downstream accept
// master = aligner side, slave = fusion core side.
// -----------------------------------------------------------------------------
interface sensor_pair_aligner_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] out_imu;
  logic [DATA_W-1:0] out_lidar;
  logic [1:0]        out_mask;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_imu, out_lidar, out_mask, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_imu, out_lidar, out_mask, out_valid,
    output out_ready
  );
endinterface

// File: rtl/sensor_pair_aligner_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Small synchronous FIFO for one sensor channel. Read data is the current
// head (first-word fall-through). Pointers carry one extra wrap bit so that
// full/empty are told apart by comparing the MSBs.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din (ignored when full unless popping the same cycle)
//   pop      : drop the head entry (ignored when empty)
//   flush    : empty the FIFO; wins over push/pop
//   din/dout : write data / head data
//   empty    : no entries
//   full     : DEPTH entries
// -----------------------------------------------------------------------------
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push on full still succeeds.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are
  // live, and a reset-free array maps onto plain RAM/flops without reset muxes.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sensor_pair_aligner.sv
// -----------------------------------------------------------------------------
// sensor_pair_aligner
// Buffers IMU and LiDAR samples in two FIFOs and pairs them into one output
// beat. A head sample that waits TIMEOUT cycles without a partner is sent
// solo with a mask; a channel running alone is sent solo immediately.
//   clk, rst                 : clock, asynchronous active-high reset
//   imu_enable, lidar_enable : channel enables; low flushes that FIFO
//   imu_data/imu_valid       : IMU sample strobe (no backpressure)
//   lidar_data/lidar_valid   : LiDAR sample strobe (no backpressure)
//   out_if (master)          : registered valid/ready output beat
//   imu_drop_cnt             : IMU samples lost to a full FIFO (saturating)
//   lidar_drop_cnt           : LiDAR samples lost to a full FIFO (saturating)
// -----------------------------------------------------------------------------
module sensor_pair_aligner
  import fusion_pkg::*;
#(
  parameter int DATA_W  = fusion_pkg::DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imu_enable,
  input  logic                  lidar_enable,
  input  logic [DATA_W-1:0]     imu_data,
  input  logic                  imu_valid,
  input  logic [DATA_W-1:0]     lidar_data,
  input  logic                  lidar_valid,
  sensor_pair_aligner_if.master out_if,
  output logic [CNT_W-1:0]      imu_drop_cnt,
  output logic [CNT_W-1:0]      lidar_drop_cnt
);

  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  logic [DATA_W-1:0] imu_head;
  logic [DATA_W-1:0] lidar_head;
  logic              imu_empty;
  logic              imu_full;
  logic              lidar_empty;
  logic              lidar_full;
  logic              imu_push;
  logic              lidar_push;
  logic              imu_pop;
  logic              lidar_pop;
  logic              imu_drop;
  logic              lidar_drop;
  logic [AGE_W-1:0]  imu_age;
  logic [AGE_W-1:0]  lidar_age;
  sel_t              sel;
  logic              load;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  assign imu_push   = imu_valid   & imu_enable   & (~imu_full   | imu_pop);
  assign lidar_push = lidar_valid & lidar_enable & (~lidar_full | lidar_pop);
  assign imu_drop   = imu_valid   & imu_enable   & imu_full   & ~imu_pop;
  assign lidar_drop = lidar_valid & lidar_enable & lidar_full & ~lidar_pop;

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_imu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (imu_push),
    .pop   (imu_pop),
    .flush (~imu_enable),
    .din   (imu_data),
    .dout  (imu_head),
    .empty (imu_empty),
    .full  (imu_full)
  );

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lidar_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (lidar_push),
    .pop   (lidar_pop),
    .flush (~lidar_enable),
    .din   (lidar_data),
    .dout  (lidar_head),
    .empty (lidar_empty),
    .full  (lidar_full)
  );

  // ---------------------------------------------------------------------------
  // Age of each head sample: cycles spent waiting, saturating at TIMEOUT.
  // ---------------------------------------------------------------------------
  function automatic logic [AGE_W-1:0] next_age(input logic [AGE_W-1:0] age,
                                                input logic             clear);
    if (clear)               return '0;
    else if (age == AGE_MAX) return age;
    else                     return age + AGE_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imu_age   <= '0;
      lidar_age <= '0;
    end else begin
      imu_age   <= next_age(imu_age,   imu_pop   | imu_empty   | ~imu_enable);
      lidar_age <= next_age(lidar_age, lidar_pop | lidar_empty | ~lidar_enable);
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration: pair first, then a lone enabled channel, then a timed-out head.
  // ---------------------------------------------------------------------------
  // NOTE: sel gets a default before any branch so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    sel = SEL_NONE;
    if (imu_enable | lidar_enable) begin
      if (!imu_empty && !lidar_empty) begin
        sel = SEL_PAIR;
      end else if (imu_enable && !lidar_enable && !imu_empty) begin
        sel = SEL_IMU;
      end else if (lidar_enable && !imu_enable && !lidar_empty) begin
        sel = SEL_LIDAR;
      end else if (imu_enable && lidar_enable && !imu_empty && imu_age == AGE_MAX) begin
        sel = SEL_IMU;
      end else if (imu_enable && lidar_enable && !lidar_empty && lidar_age == AGE_MAX) begin
        sel = SEL_LIDAR;
      end
    end
  end

  assign load      = (~out_if.out_valid | out_if.out_ready) & (sel != SEL_NONE);
  assign imu_pop   = load & ((sel == SEL_PAIR) | (sel == SEL_IMU));
  assign lidar_pop = load & ((sel == SEL_PAIR) | (sel == SEL_LIDAR));

  // ---------------------------------------------------------------------------
  // Output register: loads only when empty or being accepted, so the payload
  // is frozen while the beat is stalled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_if.out_valid <= 1'b0;
      out_if.out_imu   <= '0;
      out_if.out_lidar <= '0;
      out_if.out_mask  <= MASK_NONE;
    end else if (load) begin
      out_if.out_valid <= 1'b1;
      unique case (sel)
        SEL_PAIR: begin
          out_if.out_imu   <= imu_head;
          out_if.out_lidar <= lidar_head;
          out_if.out_mask  <= MASK_PAIR;
        end
        SEL_IMU: begin
          out_if.out_imu   <= imu_head;
          out_if.out_lidar <= '0;
          out_if.out_mask  <= MASK_IMU;
        end
        default: begin
          out_if.out_imu   <= '0;
          out_if.out_lidar <= lidar_head;
          out_if.out_mask  <= MASK_LIDAR;
        end
      endcase
    end else if (out_if.out_ready) begin
      out_if.out_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating drop counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imu_drop_cnt   <= '0;
      lidar_drop_cnt <= '0;
    end else begin
      if (imu_drop   && imu_drop_cnt   != '1) imu_drop_cnt   <= imu_drop_cnt   + 1'b1;
      if (lidar_drop && lidar_drop_cnt != '1) lidar_drop_cnt <= lidar_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sensor_pair_aligner.sv
// -----------------------------------------------------------------------------
// tb_sensor_pair_aligner
// Directed stimulus with a scoreboard: expected beats are queued when samples
// are driven, and a monitor compares every accepted output beat in order.
// -----------------------------------------------------------------------------
module tb_sensor_pair_aligner;
  import fusion_pkg::*;

  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             imu_enable;
  logic             lidar_enable;
  logic [DW-1:0]    imu_data;
  logic             imu_valid;
  logic [DW-1:0]    lidar_data;
  logic             lidar_valid;
  logic [CNT_W-1:0] imu_drop_cnt;
  logic [CNT_W-1:0] lidar_drop_cnt;

  sensor_pair_aligner_if #(.DATA_W(DW)) beat_if ();

  sensor_pair_aligner #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imu_enable     (imu_enable),
    .lidar_enable   (lidar_enable),
    .imu_data       (imu_data),
    .imu_valid      (imu_valid),
    .lidar_data     (lidar_data),
    .lidar_valid    (lidar_valid),
    .out_if         (beat_if),
    .imu_drop_cnt   (imu_drop_cnt),
    .lidar_drop_cnt (lidar_drop_cnt)
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  sensor_pair_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic sensor_pair_t mk(input logic [DW-1:0] i, input logic [DW-1:0] l,
                                      input logic [1:0] m);
    sensor_pair_t p;
    p.imu   = i;
    p.lidar = l;
    p.mask  = m;
    return p;
  endfunction

  // Monitor: an accepted beat is one seen valid & ready mid-cycle.
  always @(negedge clk) begin
    if (!rst && beat_if.out_valid && beat_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("beat_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        check("beat", {beat_if.out_imu, beat_if.out_lidar, beat_if.out_mask},
              exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic iv, input logic [DW-1:0] id,
                      input logic lv, input logic [DW-1:0] ld);
    imu_valid   = iv;
    imu_data    = id;
    lidar_valid = lv;
    lidar_data  = ld;
    cycle();
    imu_valid   = 1'b0;
    lidar_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int early;
    int unstable;

    rst               = 1'b1;
    imu_enable        = 1'b0;
    lidar_enable      = 1'b0;
    imu_data          = '0;
    imu_valid         = 1'b0;
    lidar_data        = '0;
    lidar_valid       = 1'b0;
    beat_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", beat_if.out_valid, 0);
    check("rst_out_imu",   beat_if.out_imu,   0);
    check("rst_out_lidar", beat_if.out_lidar, 0);
    check("rst_out_mask",  beat_if.out_mask,  0);
    check("rst_imu_drop",  imu_drop_cnt,      0);
    check("rst_lidar_drop", lidar_drop_cnt,   0);

    // 1: simultaneous pair, visible one cycle after the push edge
    imu_enable        = 1'b1;
    lidar_enable      = 1'b1;
    beat_if.out_ready = 1'b1;
    cycle();
    exp_q.push_back(mk(16'h1111, 16'h2222, MASK_PAIR));
    push(1'b1, 16'h1111, 1'b1, 16'h2222);
    check("t1_not_yet_valid", beat_if.out_valid, 0);
    cycle();
    check("t1_valid_next_edge", beat_if.out_valid, 1);
    wait_drain("t1_drain", 5);
    repeat (2) cycle();

    // 2: IMU alone waits TIMEOUT cycles, then goes out solo
    exp_q.push_back(mk(16'h00AA, 16'h0000, MASK_IMU));
    push(1'b1, 16'h00AA, 1'b0, 16'h0000);
    early = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      cycle();
      if (beat_if.out_valid) early++;
    end
    check("t2_no_early_beat", early, 0);
    cycle();
    check("t2_solo_valid", beat_if.out_valid, 1);
    wait_drain("t2_drain", 5);
    repeat (2) cycle();

    // 3: LiDAR disabled, IMU beats pass with no timeout wait
    lidar_enable = 1'b0;
    cycle();
    imu_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      imu_data = DW'(i);
      exp_q.push_back(mk(DW'(i), 16'h0000, MASK_IMU));
      cycle();
    end
    imu_valid = 1'b0;
    wait_drain("t3_drain", 6);
    repeat (2) cycle();

    // 4: backpressure fills both FIFOs; sixth pair is dropped
    lidar_enable      = 1'b1;
    beat_if.out_ready = 1'b0;
    cycle();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(mk(16'h0100 + DW'(i), 16'h0200 + DW'(i), MASK_PAIR));
      push(1'b1, 16'h0100 + DW'(i), 1'b1, 16'h0200 + DW'(i));
    end
    check("t4_imu_drop",   imu_drop_cnt,   1);
    check("t4_lidar_drop", lidar_drop_cnt, 1);

    // 5: stalled payload stays constant, next beat loads on accept
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if ({beat_if.out_valid, beat_if.out_imu, beat_if.out_lidar, beat_if.out_mask}
          !== {1'b1, 16'h0100, 16'h0200, 2'b11}) unstable++;
    end
    check("t5_stall_stable", unstable, 0);
    beat_if.out_ready = 1'b1;
    check("t5_hold_before_accept", beat_if.out_imu, 16'h0100);
    cycle();
    check("t5_load_on_accept", {beat_if.out_imu, beat_if.out_lidar}, {16'h0101, 16'h0201});
    wait_drain("t4_drain", 20);
    check("t4_imu_drop_kept", imu_drop_cnt, 1);
    repeat (2) cycle();

    // 6: asynchronous reset mid-stream
    beat_if.out_ready = 1'b0;
    cycle();
    for (int i = 0; i < 6; i++) begin
      push(1'b1, 16'h0300 + DW'(i), 1'b1, 16'h0400 + DW'(i));
    end
    check("t6_pre_valid",      beat_if.out_valid, 1);
    check("t6_pre_imu_drop",   imu_drop_cnt,      2);
    check("t6_pre_lidar_drop", lidar_drop_cnt,    2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid",      beat_if.out_valid, 0);
    check("t6_rst_mask",       beat_if.out_mask,  0);
    check("t6_rst_imu",        beat_if.out_imu,   0);
    check("t6_rst_imu_drop",   imu_drop_cnt,      0);
    check("t6_rst_lidar_drop", lidar_drop_cnt,    0);
    cycle();
    rst               = 1'b0;
    beat_if.out_ready = 1'b1;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (beat_if.out_valid) early++;
    end
    check("t6_fifos_empty", early, 0);
    exp_q.push_back(mk(16'h0F0F, 16'hF0F0, MASK_PAIR));
    push(1'b1, 16'h0F0F, 1'b1, 16'hF0F0);
    wait_drain("t6_drain", 6);
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
